sme_lfsr32_checker: RTL
=======================

Name: sme_lfsr32_checker

Overview:
Receive-side checker for the 32-bit SME PRNG sequence (update rule given under Behaviour). It observes successive PRNG words plus the extra tap bit used for each update. It predicts the next word, locks onto the sequence and counts mismatches. It is used as an on-chip self-test monitor for the masking PRNG: it flags stuck, skipped or corrupted updates to the security/diagnostic logic.

Parameters:
LOCK_COUNT, 8, consecutive correct predictions needed to enter LOCKED (>=1)
UNLOCK_COUNT, 4, consecutive mispredictions in LOCKED that force return to HUNT (>=1)
ERR_W, 16, width of saturating error counter

Ports:
g_clk  input  1  clock
g_resetn  input  1  asynchronous active-low reset
clear  input  1  synchronous clear: err_count to 0, FSM to HUNT
sample_valid  input  1  sample/sample_tap valid this cycle (one PRNG update)
sample  input  32  PRNG word observed after the update
sample_tap  input  1  extra_tap value applied to produce this sample
locked  output  1  checker is in LOCKED
err_pulse  output  1  one-cycle pulse: misprediction detected in LOCKED
err_count  output  ERR_W  saturating count of LOCKED mispredictions
lost_lock  output  1  one-cycle pulse: LOCKED -> HUNT transition

Behaviour:
- Prediction function, from ref R and tap t: lsb = ~(R[31]^R[21]^R[1]^R[0]) ^ t; pred = {R[30:0], lsb}.
- Internal state: ref[31:0], fsm {HUNT, VERIFY, LOCKED}, good_cnt, bad_cnt.
- Reset (async, g_resetn=0):
  - fsm=HUNT, ref=0, counters=0.
  - locked=0, err_pulse=0, err_count=0, lost_lock=0.
- All outputs are registered. A sample accepted at edge N is reflected at edge N+1.
- Cycles with sample_valid=0 change nothing, and pulses drop to 0.
- HUNT, valid sample: ref<=sample, good_cnt<=0, go to VERIFY. No comparison is made.
- VERIFY, valid sample:
  - If sample==pred(ref, sample_tap): ref<=sample and good_cnt++.
  - If good_cnt reaches LOCK_COUNT: go to LOCKED, locked<=1, bad_cnt<=0.
  - On mismatch: ref<=sample (resync), good_cnt<=0, stay in VERIFY. err_count does not change.
- LOCKED, valid sample:
  - Match: ref<=sample, bad_cnt<=0.
  - Mismatch: ref<=pred (free-run; do not resync to the bad sample), err_pulse<=1, err_count++ (saturates at all-ones), bad_cnt++.
  - If bad_cnt reaches UNLOCK_COUNT: go to HUNT, locked<=0, lost_lock<=1, counters cleared.
- clear has priority over sample processing in the same cycle:
  - FSM<=HUNT, err_count<=0, locked<=0.
  - err_pulse and lost_lock are 0 in the following cycle.
  - The sample presented with clear is discarded.
- err_count saturation: at 2^ERR_W-1, further mispredictions still pulse err_pulse, but the count holds.
- An async reset mid-sequence returns to the reset state immediately. The next valid sample after release is treated as a HUNT seed.
- The all-zero word is a legal sample: with tap=0 the predicted successor of 0 is 0x00000001. There is no special casing.
- Throughput is one sample per cycle with no backpressure. Back-to-back valid samples must be supported.

Test Plan:
- Reset, then feed 0x6789ABCD (tap 0) followed by 0xCF13579A (tap 0) -> VERIFY with good_cnt=1, locked=0, err_count=0.
- Seed 0x6789ABCD, then 8 correctly generated successors, back-to-back (tap 0) -> locked=1 exactly one cycle after the 8th; err_pulse never asserted.
- While LOCKED, inject one corrupted word (flip bit 5), then resume the correct sequence -> one err_pulse, err_count=1, locked stays 1, following samples match (free-run ref).
- While LOCKED, feed 4 consecutive wrong words -> err_pulse on each, err_count=4, lost_lock pulse with the 4th, locked=0. The next sample reseeds (HUNT -> VERIFY).
- Sequence with sample_tap=1 on alternate updates versus the checker given the same taps -> locks, no errors. The same stream with sample_tap forced to 0 -> mismatches; VERIFY keeps resyncing and never locks.
- ERR_W=2: 5 isolated mispredictions in LOCKED -> err_count saturates at 3 with 5 err_pulses. Assert clear with a valid sample -> err_count=0, FSM in HUNT, that sample is ignored. Pulse g_resetn low mid-stream -> all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/sme_lfsr32_checker.sv
// Receive-side monitor for the 32-bit SME masking PRNG: predicts each update,
// locks onto the stream and counts mispredictions seen while locked.
module sme_lfsr32_checker #(
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 4,
    parameter int ERR_W        = 16
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [31:0]      sample,
    input  logic             sample_tap,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             lost_lock
);

    localparam int GW = (LOCK_COUNT   < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int BW = (UNLOCK_COUNT < 1) ? 1 : $clog2(UNLOCK_COUNT + 1);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      ref_q, ref_d;
    logic [GW-1:0]    good_q, good_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic             locked_q, locked_d;
    logic             pulse_q, pulse_d;
    logic             lost_q, lost_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic [31:0]      pred;
    logic             match;
    logic [GW-1:0]    good_inc;
    logic [BW-1:0]    bad_inc;

    function automatic logic [31:0] predict(input logic [31:0] r, input logic t);
        return {r[30:0], ~(r[31] ^ r[21] ^ r[1] ^ r[0]) ^ t};
    endfunction

    assign pred     = predict(ref_q, sample_tap);
    assign match    = (sample == pred);
    assign good_inc = good_q + GW'(1);
    assign bad_inc  = bad_q + BW'(1);

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        good_d   = good_q;
        bad_d    = bad_q;
        locked_d = locked_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        lost_d   = 1'b0;

        if (clear) begin
            // The sample presented alongside clear is dropped, not used as a seed.
            state_d  = ST_HUNT;
            good_d   = '0;
            bad_d    = '0;
            locked_d = 1'b0;
            cnt_d    = '0;
        end else if (sample_valid) begin
            case (state_q)
                ST_HUNT: begin
                    ref_d   = sample;
                    good_d  = '0;
                    state_d = ST_VERIFY;
                end
                ST_VERIFY: begin
                    ref_d = sample;
                    if (match) begin
                        good_d = good_inc;
                        if (good_inc == GW'(LOCK_COUNT)) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            good_d   = '0;
                            bad_d    = '0;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        ref_d = sample;
                        bad_d = '0;
                    end else begin
                        // Free-run on the prediction so one bad word cannot derail tracking.
                        ref_d   = pred;
                        pulse_d = 1'b1;
                        if (cnt_q != {ERR_W{1'b1}}) begin
                            cnt_d = cnt_q + ERR_W'(1);
                        end
                        if (bad_inc == BW'(UNLOCK_COUNT)) begin
                            state_d  = ST_HUNT;
                            locked_d = 1'b0;
                            lost_d   = 1'b1;
                            good_d   = '0;
                            bad_d    = '0;
                        end else begin
                            bad_d = bad_inc;
                        end
                    end
                end
                default: begin
                    state_d  = ST_HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q  <= ST_HUNT;
            ref_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
            lost_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            locked_q <= locked_d;
            pulse_q  <= pulse_d;
            lost_q   <= lost_d;
            cnt_q    <= cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_count = cnt_q;
    assign lost_lock = lost_q;

endmodule
